// File: rtl/boot_load_ctrl.sv
// Boot loader that owns the shared memory port after reset. It assembles a UART byte stream
// (a word-count header, then little-endian data words) into memory writes, then hands the port over.
module boot_load_ctrl #(
  parameter int               ADDRW     = 32,
  parameter int               DATAW     = 32,
  parameter logic [ADDRW-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 16384
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             io_sel,
  output logic [ADDRW-1:0] addr_io,
  output logic [DATAW-1:0] data_io,
  output logic             we_io,
  output logic             proc_rstn,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int CNTW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, SIZE, LOAD, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      buf_q, buf_d;
  logic [31:0]      rem_q, rem_d;
  logic [CNTW-1:0]  wr_idx_q, wr_idx_d;
  logic             fin_q, fin_d;
  logic             io_sel_q, io_sel_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] data_q, data_d;
  logic             we_q, we_d;
  logic             proc_rstn_q, proc_rstn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             word_done;
  logic [DATAW-1:0] word;

  assign word = {rx_data, buf_q};

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    rem_d      = rem_q;
    wr_idx_d   = wr_idx_q;
    fin_d      = fin_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    we_d       = 1'b0;

    // Bytes are accepted until the final word has been assembled; later strobes are dropped.
    accept    = rx_valid && (state_q != DONE) && !fin_q;
    word_done = accept && (byte_idx_q == 2'd3);

    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    buf_d[7:0]   = rx_data;
        2'd1:    buf_d[15:8]  = rx_data;
        2'd2:    buf_d[23:16] = rx_data;
        default: buf_d        = buf_q;
      endcase
    end

    case (state_q)
      IDLE: if (accept) state_d = SIZE;
      SIZE: begin
        if (word_done) begin
          rem_d   = word;
          state_d = (word == 32'd0) ? DONE : LOAD;
          if (word > 32'(MAX_WORDS)) ovf_d = 1'b1;
        end
      end
      LOAD: begin
        // Stay in LOAD for the final write pulse; hand over one cycle later.
        if (fin_q) begin
          state_d = DONE;
        end else if (word_done) begin
          if (wr_idx_q < CNTW'(MAX_WORDS)) begin
            we_d     = 1'b1;
            addr_d   = BASE_ADDR + (ADDRW'(wr_idx_q) << 2);
            data_d   = word;
            wr_idx_d = wr_idx_q + 1'b1;
          end
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) fin_d = 1'b1;
        end
      end
      default: state_d = DONE;
    endcase

    io_sel_d    = (state_d != DONE);
    proc_rstn_d = (state_d == DONE);
    done_d      = (state_d == DONE);
    busy_d      = (state_d == SIZE) || (state_d == LOAD);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      byte_idx_q  <= 2'd0;
      buf_q       <= '0;
      rem_q       <= '0;
      wr_idx_q    <= '0;
      fin_q       <= 1'b0;
      io_sel_q    <= 1'b1;
      addr_q      <= BASE_ADDR;
      data_q      <= '0;
      we_q        <= 1'b0;
      proc_rstn_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      rem_q       <= rem_d;
      wr_idx_q    <= wr_idx_d;
      fin_q       <= fin_d;
      io_sel_q    <= io_sel_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      proc_rstn_q <= proc_rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign io_sel    = io_sel_q;
  assign addr_io   = addr_q;
  assign data_io   = data_q;
  assign we_io     = we_q;
  assign proc_rstn = proc_rstn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Bench for boot_load_ctrl: a full-size loader (nonzero base) and a 2-word loader share clk/rstn.
// Expected writes are queued when a word's last byte is driven and popped when we_io pulses.
module tb_boot_load_ctrl;

  localparam logic [31:0] BASE_A = 32'h0000_1000;
  localparam logic [31:0] BASE_B = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid_a = 1'b0;
  logic        rx_valid_b = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        io_sel_a, we_a, proc_rstn_a, busy_a, done_a, ovf_a;
  logic [31:0] addr_a, data_a;
  logic        io_sel_b, we_b, proc_rstn_b, busy_b, done_b, ovf_b;
  logic [31:0] addr_b, data_b;

  wr_t q_a[$];
  wr_t q_b[$];
  int  checks_total = 0;
  int  checks_passed = 0;

  always #5 clk = ~clk;

  boot_load_ctrl #(.ADDRW(32), .DATAW(32), .BASE_ADDR(BASE_A), .MAX_WORDS(16384)) dut_a (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid_a), .rx_data(rx_data),
    .io_sel(io_sel_a), .addr_io(addr_a), .data_io(data_a), .we_io(we_a),
    .proc_rstn(proc_rstn_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  boot_load_ctrl #(.ADDRW(32), .DATAW(32), .BASE_ADDR(BASE_B), .MAX_WORDS(2)) dut_b (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid_b), .rx_data(rx_data),
    .io_sel(io_sel_b), .addr_io(addr_b), .data_io(data_b), .we_io(we_b),
    .proc_rstn(proc_rstn_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Consecutive calls give back-to-back strobes: valid is sampled high on every posedge.
  task automatic send_byte(input bit sel, input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    if (sel) rx_valid_b = 1'b1;
    else     rx_valid_a = 1'b1;
    @(posedge clk);
    #1;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  // Sends a word LSB first; checks the write pulse appears exactly one cycle after byte 3.
  task automatic send_word(input bit sel, input logic [31:0] w, input bit exp_we,
                           input logic [31:0] exp_addr, input string tag);
    wr_t e;
    for (int k = 0; k < 3; k++) send_byte(sel, w[8*k +: 8]);
    if (exp_we) begin
      e.addr = exp_addr;
      e.data = w;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    send_byte(sel, w[31:24]);
    check(tag, {31'b0, sel ? we_b : we_a}, {31'b0, exp_we});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (we_a) begin
      check("a_write_expected", 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_addr", addr_a, e.addr);
        check("a_data", data_a, e.data);
      end
    end
    if (we_b) begin
      check("b_write_expected", 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_addr", addr_b, e.addr);
        check("b_data", data_b, e.data);
      end
    end
  end

  initial begin
    // Reset values
    apply_reset();
    check("rst_io_sel", {31'b0, io_sel_a}, 32'd1);
    check("rst_we", {31'b0, we_a}, 32'd0);
    check("rst_addr", addr_a, BASE_A);
    check("rst_data", data_a, 32'd0);
    check("rst_flags", {28'b0, proc_rstn_a, busy_a, done_a, ovf_a}, 32'd0);

    // Test 1: N=2 with idle gaps between words
    send_word(1'b0, 32'd2, 1'b0, 32'd0, "t1_hdr_no_we");
    check("t1_busy", {31'b0, busy_a}, 32'd1);
    idle(2);
    send_word(1'b0, 32'h1122_3344, 1'b1, BASE_A + 32'd0, "t1_w0_latency");
    idle(3);
    send_word(1'b0, 32'hAABB_CCDD, 1'b1, BASE_A + 32'd4, "t1_w1_latency");
    check("t1_pulse_before_handover", {29'b0, io_sel_a, proc_rstn_a, done_a}, 32'b100);
    idle(1);
    check("t1_handover", {27'b0, io_sel_a, proc_rstn_a, done_a, we_a, busy_a}, 32'b01100);
    check("t1_ovf", {31'b0, ovf_a}, 32'd0);

    // Test 6: strobes in DONE are ignored
    for (int k = 0; k < 4; k++) begin
      send_byte(1'b0, 8'h5A + 8'(k));
      check("t6_no_we", {31'b0, we_a}, 32'd0);
    end
    idle(1);
    check("t6_state_held", {28'b0, io_sel_a, proc_rstn_a, done_a, we_a}, 32'b0110);

    // Test 2: N=0 goes straight to DONE one cycle after the last header byte
    apply_reset();
    send_word(1'b0, 32'd0, 1'b0, 32'd0, "t2_hdr_no_we");
    check("t2_done", {29'b0, io_sel_a, proc_rstn_a, done_a}, 32'b011);
    idle(2);
    check("t2_still_no_we", {31'b0, we_a}, 32'd0);

    // Test 3: N=3, every byte back-to-back
    apply_reset();
    send_word(1'b0, 32'd3, 1'b0, 32'd0, "t3_hdr_no_we");
    send_word(1'b0, 32'hDEAD_BEEF, 1'b1, BASE_A + 32'd0, "t3_w0_latency");
    send_word(1'b0, 32'h0BAD_F00D, 1'b1, BASE_A + 32'd4, "t3_w1_latency");
    send_word(1'b0, 32'h1357_9BDF, 1'b1, BASE_A + 32'd8, "t3_w2_latency");
    idle(1);
    check("t3_done", {29'b0, io_sel_a, proc_rstn_a, done_a}, 32'b011);

    // Test 5: reset mid-word, then a fresh N=1 image
    apply_reset();
    send_word(1'b0, 32'd2, 1'b0, 32'd0, "t5_hdr_no_we");
    send_word(1'b0, 32'h0102_0304, 1'b1, BASE_A + 32'd0, "t5_w0_latency");
    send_byte(1'b0, 8'hEE);
    send_byte(1'b0, 8'hFF);
    apply_reset();
    check("t5_rst_ports", {28'b0, io_sel_a, proc_rstn_a, busy_a, done_a}, 32'b1000);
    check("t5_rst_addr", addr_a, BASE_A);
    send_word(1'b0, 32'd1, 1'b0, 32'd0, "t5_hdr2_no_we");
    send_word(1'b0, 32'hCAFE_F00D, 1'b1, BASE_A + 32'd0, "t5_fresh_latency");
    idle(1);
    check("t5_done", {31'b0, done_a}, 32'd1);

    // Test 4: capacity 2, header N=3
    apply_reset();
    send_word(1'b1, 32'd3, 1'b0, 32'd0, "t4_hdr_no_we");
    check("t4_ovf", {31'b0, ovf_b}, 32'd1);
    check("t4_busy", {31'b0, busy_b}, 32'd1);
    send_word(1'b1, 32'h2222_0000, 1'b1, BASE_B + 32'd0, "t4_w0_latency");
    send_word(1'b1, 32'h3333_1111, 1'b1, BASE_B + 32'd4, "t4_w1_latency");
    check("t4_not_done_early", {31'b0, done_b}, 32'd0);
    send_word(1'b1, 32'h4444_2222, 1'b0, 32'd0, "t4_w2_dropped");
    idle(1);
    check("t4_done", {28'b0, io_sel_b, proc_rstn_b, done_b, ovf_b}, 32'b0111);
    check("t4_a_untouched", {30'b0, busy_a, io_sel_a}, 32'b01);

    idle(2);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
